// File: rtl/bus_sram_responder.sv
// Responder end of the burst bus: serialises write and read bursts (up to 15 words) onto a single-port synchronous SRAM.
// Optional BUS_RESP_READ_STREAM_EN: pipelined read path with a 2-entry output FIFO instead of 3 cycles per read beat.

package bundle;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] waddr;
    logic [3:0]  wlen;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  rlen;
    logic        rready;
  } bus_query_req_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } bus_query_resp_t;

endpackage

module bus_sram_responder
  import bundle::*;
#(
  parameter int SRAM_AW = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  bus_query_req_t     req,
  output bus_query_resp_t    resp,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_be,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam logic [SRAM_AW-1:0] ADDR_ONE = {{(SRAM_AW-1){1'b0}}, 1'b1};

`ifdef BUS_RESP_READ_STREAM_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RSTREAM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RWAIT,
    S_RDATA
  } state_t;
`endif

  state_t             state_r;
  logic [SRAM_AW-1:0] addr_r;
  logic [3:0]         len_r;
  logic [3:0]         beat_r;
  logic               aw_take_s;
  logic               ar_take_s;
  logic               wr_end_s;
  logic               unused_s;

`ifdef BUS_RESP_READ_STREAM_EN
  logic [31:0]        fifo_data_r [2];
  logic [1:0]         fifo_last_r;
  logic               fifo_wp_r;
  logic               fifo_rp_r;
  logic [1:0]         fifo_cnt_r;
  logic               inflight_r;
  logic               inflight_last_r;
  logic               pop_s;
  logic               issue_s;
  logic [2:0]         occ_s;
`else
  logic [31:0]        rdata_r;
  logic               rlast_r;
`endif

  // A zero-length request is not a request; a write wins over a simultaneous read.
  assign aw_take_s = req.awvalid && (req.wlen != 4'd0);
  assign ar_take_s = req.arvalid && (req.rlen != 4'd0) && !aw_take_s;
  assign wr_end_s  = req.wlast || (beat_r == len_r);
  assign unused_s  = ^{req.waddr[31:SRAM_AW+2], req.waddr[1:0],
                       req.araddr[31:SRAM_AW+2], req.araddr[1:0]};

`ifdef BUS_RESP_READ_STREAM_EN
  // Occupancy counts reads already in flight so back-pressure can never overflow the FIFO.
  assign pop_s   = (fifo_cnt_r != 2'd0) && req.rready;
  assign occ_s   = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s = (state_r == S_RSTREAM) && (len_r != 4'd0) && (occ_s < 3'd2);
`endif

  // Transaction FSM: burst address/length tracking and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      addr_r          <= '0;
      len_r           <= 4'd0;
      beat_r          <= 4'd0;
`ifdef BUS_RESP_READ_STREAM_EN
      fifo_data_r[0]  <= 32'd0;
      fifo_data_r[1]  <= 32'd0;
      fifo_last_r     <= 2'b00;
      fifo_wp_r       <= 1'b0;
      fifo_rp_r       <= 1'b0;
      fifo_cnt_r      <= 2'd0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
`else
      rdata_r         <= 32'd0;
      rlast_r         <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (aw_take_s) begin
            addr_r  <= req.waddr[SRAM_AW+1:2];
            len_r   <= req.wlen;
            beat_r  <= 4'd1;
            state_r <= S_WDATA;
          end else if (ar_take_s) begin
            addr_r  <= req.araddr[SRAM_AW+1:2];
            len_r   <= req.rlen;
`ifdef BUS_RESP_READ_STREAM_EN
            state_r <= S_RSTREAM;
`else
            state_r <= S_RADDR;
`endif
          end
        end
        S_WDATA: begin
          if (req.wvalid) begin
            addr_r <= addr_r + ADDR_ONE;
            beat_r <= beat_r + 4'd1;
            if (wr_end_s) begin
              state_r <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (req.bready) begin
            state_r <= S_IDLE;
          end
        end
`ifdef BUS_RESP_READ_STREAM_EN
        S_RSTREAM: begin
          if (issue_s) begin
            addr_r <= addr_r + ADDR_ONE;
            len_r  <= len_r - 4'd1;
          end
          inflight_r      <= issue_s;
          inflight_last_r <= (len_r == 4'd1);
          if (inflight_r) begin
            fifo_data_r[fifo_wp_r] <= sram_rdata;
            fifo_last_r[fifo_wp_r] <= inflight_last_r;
            fifo_wp_r              <= !fifo_wp_r;
          end
          if (pop_s) begin
            fifo_rp_r <= !fifo_rp_r;
          end
          fifo_cnt_r <= fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
          // The tagged last beat is always the final one, so nothing is pending behind it.
          if (pop_s && fifo_last_r[fifo_rp_r]) begin
            state_r <= S_IDLE;
          end
        end
`else
        S_RADDR: begin
          addr_r  <= addr_r + ADDR_ONE;
          state_r <= S_RWAIT;
        end
        S_RWAIT: begin
          rdata_r <= sram_rdata;
          rlast_r <= (len_r == 4'd1);
          state_r <= S_RDATA;
        end
        S_RDATA: begin
          if (req.rready) begin
            len_r   <= len_r - 4'd1;
            rlast_r <= 1'b0;
            state_r <= (len_r == 4'd1) ? S_IDLE : S_RADDR;
          end
        end
`endif
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Bus-side handshakes and read data.
  always_comb begin
    resp         = '0;
    resp.awready = (state_r == S_IDLE);
    resp.rready  = (state_r == S_IDLE) && !aw_take_s;
    resp.wready  = (state_r == S_WDATA) && req.wvalid;
    resp.bvalid  = (state_r == S_WRESP);
`ifdef BUS_RESP_READ_STREAM_EN
    resp.rvalid  = (fifo_cnt_r != 2'd0);
    resp.rdata   = fifo_data_r[fifo_rp_r];
    resp.rlast   = (fifo_cnt_r != 2'd0) && fifo_last_r[fifo_rp_r];
`else
    resp.rvalid  = (state_r == S_RDATA);
    resp.rdata   = rdata_r;
    resp.rlast   = rlast_r;
`endif
  end

  // SRAM port: write beats pass straight through, reads are issued from the FSM.
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = addr_r;
    sram_be    = 4'h0;
    sram_wdata = 32'h0;
    if ((state_r == S_WDATA) && req.wvalid) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_be    = req.wstrb;
      sram_wdata = req.wdata;
`ifdef BUS_RESP_READ_STREAM_EN
    end else if (issue_s) begin
`else
    end else if (state_r == S_RADDR) begin
`endif
      sram_ce = 1'b1;
    end else begin
      sram_ce = 1'b0;
    end
  end

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

Responder (slave) end of the core's self-defined burst bus. It accepts `bus_query_req_t` transactions from a bus initiator (fetch/LSU/cache refill) and answers with `bus_query_resp_t`. Accepted requests are executed against a single-port synchronous SRAM, with bursts of up to 15 words. The block sits between the core-side bus and on-chip RAM, serialising write and read bursts through one FSM.

## Interface
- `SRAM_AW`, default 20: SRAM word-address width; the SRAM holds 2^SRAM_AW words.
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  `bus_query_req_t`  request from the initiator (`bundle` package).
- `resp`  out  `bus_query_resp_t`  response. `resp.rready` is the read-address-accept (arready) signal.
- `sram_ce`  out  1  SRAM access enable.
- `sram_we`  out  1  SRAM write enable, qualified by `sram_ce`.
- `sram_addr`  out  SRAM_AW  SRAM word address.
- `sram_be`  out  4  SRAM byte enables.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data, valid in the cycle after a read `sram_ce`.

## Operation
- FSM states and transitions:
  - IDLE → WDATA when `awvalid && wlen!=0`.
  - IDLE → RADDR when `arvalid && rlen!=0` and no write is taken.
  - WDATA → WRESP.
  - WRESP → IDLE.
  - RADDR → RWAIT → RDATA → (RADDR | IDLE).
- In IDLE, `awready`=1. `resp.rready` = !(`awvalid && wlen!=0`), so a write wins when both requests arrive in the same cycle.
- A request with `len==0` is not a request: it is ignored and the FSM stays in IDLE.
- On accept, latch the word address `addr[SRAM_AW+1:2]` and the length. Each beat adds 1 to the address, modulo 2^SRAM_AW; wrap-around is silent. `addr[1:0]` is ignored.
- WDATA:
  - `wready` = `wvalid` (combinational).
  - When `wvalid` is high, drive `sram_ce`=`sram_we`=1, `sram_be`=`wstrb`, `sram_wdata`=`wdata`.
  - The burst ends on the beat where the beat count equals `wlen`, or where `wlast`=1, whichever comes first. Then go to WRESP.
- WRESP: `bvalid`=1 until `bready`, then go to IDLE.
- Read, base mode:
  - RADDR: drive `sram_ce`=1, `sram_we`=0.
  - RWAIT: capture `sram_rdata` into the `rdata` register.
  - RDATA: `rvalid`=1 and `rdata` are held until `req.rready`. `rlast`=1 on the final beat.
  - When a beat is consumed, go to RADDR if beats remain, else to IDLE.
- `awvalid`/`arvalid` are not re-sampled outside IDLE.

## Timing
- Reset values: `rvalid`, `rlast`, `bvalid`, `wready`, `sram_ce`, `sram_we` = 0. `rdata`, `sram_addr`, `sram_be`, `sram_wdata` = 0. State = IDLE.
- Since state is IDLE, `awready`=`resp.rready`=1 in the first cycle after reset.
- Reset mid-burst: the burst is abandoned next edge and no further SRAM access occurs. The initiator must also reset.
- Write path, with AW accepted in cycle 0:
  - Beats are accepted from cycle 1, up to one per cycle.
  - `bvalid` rises the cycle after the last beat.
- Read path, base mode, with AR accepted in cycle 0:
  - First SRAM read in cycle 1; `rvalid` in cycle 3.
  - With `req.rready` held high, beat n is visible in cycle 3+3n.
- `rdata` must not change while `rvalid` && !`req.rready`.

## Configuration
- `BUS_RESP_READ_STREAM_EN` defined:
  - RADDR/RWAIT/RDATA are replaced by a streaming read with a 2-entry output FIFO.
  - A read is issued whenever beats remain and (FIFO occupancy + in-flight − consume this cycle) < 2.
  - `rvalid` = FIFO non-empty; `rlast` is tagged per entry.
  - With `req.rready` held high, first `rvalid` is in cycle 3, then one beat per cycle.
  - Back-pressure must never overflow the FIFO or drop a beat.
- Undefined: base 3-cycle-per-beat read.
- The write path is identical in both builds.

## Test plan
- Reset, then idle → `awready`=`resp.rready`=1, all valids 0, `sram_ce`=0.
- Write burst: `waddr`=0x100, `wlen`=4, data 0xA0..0xA3, `wvalid` held high, `wstrb`=0xF → SRAM words 0x40..0x43 written on 4 consecutive cycles, `bvalid` one cycle later.
- Read back: `araddr`=0x100, `rlen`=4 with `rready` held high → rdata 0xA0..0xA3 in order, `rlast` only on 0xA3. Base mode: beats at cycles 3/6/9/12. Stream mode: beats at cycles 3/4/5/6.
- Simultaneous `awvalid` and `arvalid` in IDLE → write taken, `resp.rready`=0 that cycle. Read accepted after `bready`.
- Read with `rready` toggling 1-0-0-1 → `rdata` stable while stalled, no beat lost or duplicated, FIFO never exceeds 2 entries.
- Write `wlen`=3 at the top SRAM word with `wlast` on beat 2 → addresses wrap to 0, burst ends after 2 beats, `wstrb`=0x3 gives `sram_be`=0x3.
